// File: rtl/gpio_display_sequencer.sv
// Converts a 32-bit value to BCD and writes the 14 VGA display registers through a
// GPIO port shared with the CPU; the CPU always wins the port.
module gpio_display_sequencer #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter bit          LZ_BLANK   = 1'b1,
  parameter logic [7:0]  BLANK_CODE = 8'h0A
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_wr_en,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_dat_i,
  input  logic        start,
  input  logic [31:0] value,
  input  logic        signed_mode,
  input  logic [3:0]  point,
  output logic        busy,
  output logic        done,
  output logic        gpio_wr_en,
  output logic [31:0] gpio_addr,
  output logic [31:0] gpio_dat
);

  // Command handshake: start is a one-cycle strobe accepted only while busy=0;
  // busy stays high until done has pulsed for exactly one cycle.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CONV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  logic [3:0]  r_idx;
  logic [4:0]  r_cnt;
  logic [39:0] r_bcd;
  logic [31:0] r_mag;
  logic        r_neg;
  logic [3:0]  r_pt;

  logic [39:0] w_bcd_adj;
  logic [3:0]  w_msd;
  logic [3:0]  w_nib;
  logic [7:0]  w_code;
  logic        w_seq_grant;
  logic        w_neg_in;

  always_comb begin
    w_bcd_adj = '0;
    for (int i = 0; i < 10; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      else                         w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4];
    end
  end

  // Highest nonzero digit; an all-zero value keeps msd at 0 so digit 0 always shows.
  always_comb begin
    w_msd = '0;
    for (int i = 1; i < 10; i++) begin
      if (r_bcd[4*i +: 4] != 4'd0) w_msd = 4'(i);
    end
  end

  always_comb begin
    w_nib = '0;
    for (int i = 0; i < 10; i++) begin
      if (r_idx == 4'(i)) w_nib = r_bcd[4*i +: 4];
    end
  end

  always_comb begin
    w_code = 8'h00;
    if (r_idx <= 4'd11) begin
      if (LZ_BLANK && (r_idx > w_msd) && (r_idx > r_pt)) w_code = BLANK_CODE;
      else                                                w_code = {4'b0, w_nib};
    end else if (r_idx == 4'd12) begin
      w_code = {4'b0, r_pt};
    end else begin
      w_code = {7'b0, r_neg};
    end
  end

  assign w_seq_grant = (r_state == S_WRITE) && !cpu_req;
  assign w_neg_in    = signed_mode & value[31];

  always_comb begin
    if (w_seq_grant) begin
      gpio_wr_en = 1'b1;
      gpio_addr  = BASE_ADDR + {28'b0, r_idx};
      gpio_dat   = {24'b0, w_code};
    end else begin
      gpio_wr_en = cpu_wr_en;
      gpio_addr  = cpu_addr;
      gpio_dat   = cpu_dat_i;
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_bcd   <= '0;
      r_mag   <= '0;
      r_neg   <= 1'b0;
      r_pt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mag   <= w_neg_in ? (~value + 32'd1) : value;
            r_neg   <= w_neg_in;
            r_pt    <= (point > 4'd11) ? 4'd11 : point;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_state <= S_CONV;
          end
        end
        S_CONV: begin
          // One double-dabble step: correct the digits, then shift in the next magnitude bit.
          {r_bcd, r_mag} <= {w_bcd_adj, r_mag} << 1;
          r_cnt          <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_idx   <= '0;
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (!cpu_req) begin
            if (r_idx == 4'd13) begin
              r_idx   <= '0;
              r_state <= S_DONE;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_display_sequencer.sv
// Directed bench for gpio_display_sequencer: records every sequencer write and the
// resulting display contents, then compares against hand-computed values.
module tb_gpio_display_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req;
  logic        cpu_wr_en;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_dat_i;
  logic        start;
  logic [31:0] value;
  logic        signed_mode;
  logic [3:0]  point;
  logic        busy;
  logic        done;
  logic        gpio_wr_en;
  logic [31:0] gpio_addr;
  logic [31:0] gpio_dat;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] seq_addr[$];
  logic [31:0] seq_dat[$];
  int          seq_cyc[$];
  logic [7:0]  exp_q[$];
  logic        busy_log[0:127];
  logic        done_log[0:127];
  logic [7:0]  mem[0:13];
  int          pass_err;

  gpio_display_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu_req     (cpu_req),
    .cpu_wr_en   (cpu_wr_en),
    .cpu_addr    (cpu_addr),
    .cpu_dat_i   (cpu_dat_i),
    .start       (start),
    .value       (value),
    .signed_mode (signed_mode),
    .point       (point),
    .busy        (busy),
    .done        (done),
    .gpio_wr_en  (gpio_wr_en),
    .gpio_addr   (gpio_addr),
    .gpio_dat    (gpio_dat)
  );

  always #5 clk = ~clk;

  // Cycle n is the n-th cycle after the edge that samples start.
  task automatic run_cmd(input logic [31:0] v, input logic sm, input logic [3:0] pt,
                         input int stall_at, input int stall_len, input int xs1,
                         input int xs2, input int rst_at, input int ncyc);
    seq_addr.delete();
    seq_dat.delete();
    seq_cyc.delete();
    pass_err = 0;
    for (int i = 0; i < 128; i++) begin
      busy_log[i] = 1'b0;
      done_log[i] = 1'b0;
    end
    for (int i = 0; i < 14; i++) mem[i] = 8'hEE;
    @(negedge clk);
    value = v; signed_mode = sm; point = pt; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; value = 32'hDEAD_BEEF; signed_mode = 1'b1; point = 4'd9;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      start = (n == xs1) || (n == xs2);
      if (start) value = 32'd999;
      cpu_req   = (stall_len > 0) && (n >= stall_at) && (n < stall_at + stall_len);
      cpu_wr_en = cpu_req && (n == stall_at + 1);
      cpu_addr  = cpu_wr_en ? 32'd7 : 32'(32'h100 + n);
      cpu_dat_i = cpu_wr_en ? 32'h55 : $urandom;
      rst_n     = (n != rst_at);
      #1;
      busy_log[n] = busy;
      done_log[n] = done;
      if (cpu_req && (gpio_wr_en !== cpu_wr_en || gpio_addr !== cpu_addr || gpio_dat !== cpu_dat_i))
        pass_err++;
      if (gpio_wr_en === 1'b1 && gpio_addr < 32'd14) mem[gpio_addr[3:0]] = gpio_dat[7:0];
      if (gpio_wr_en === 1'b1 && !cpu_req) begin
        seq_addr.push_back(gpio_addr);
        seq_dat.push_back(gpio_dat);
        seq_cyc.push_back(n);
      end
    end
    @(negedge clk);
    start = 1'b0; cpu_req = 1'b0; cpu_wr_en = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; cpu_req = 1'b0; cpu_wr_en = 1'b0;
    cpu_addr = '0; cpu_dat_i = '0; value = '0; signed_mode = 1'b0; point = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cpu_wr_en = 1'b1; cpu_addr = 32'd5; cpu_dat_i = 32'h1234;
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_status: busy=%b done=%b, expected busy=0 done=0", busy, done);
    end
    vectors++;
    if (gpio_wr_en !== 1'b1 || gpio_addr !== 32'd5 || gpio_dat !== 32'h1234) begin
      miscompares++;
      $display("FAIL reset_passthru: wr=%b addr=%0h dat=%0h, expected wr=1 addr=5 dat=1234",
               gpio_wr_en, gpio_addr, gpio_dat);
    end
    @(negedge clk);
    cpu_wr_en = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_unsigned();
    run_cmd(32'd1234, 1'b0, 4'd0, 0, 0, 0, 0, 0, 48);
    exp_q = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h0A, 8'h0A, 8'h0A, 8'h0A,
              8'h0A, 8'h0A, 8'h0A, 8'h0A, 8'h00, 8'h00};
    vectors++;
    if (seq_dat.size() != 14) begin
      miscompares++;
      $display("FAIL unsigned_count: %0d writes, expected 14", seq_dat.size());
    end
    for (int i = 0; i < 14 && i < seq_dat.size(); i++) begin
      vectors++;
      if (seq_addr[i] !== 32'(i) || seq_dat[i] !== {24'b0, exp_q[i]} || seq_cyc[i] != 33 + i) begin
        miscompares++;
        $display("FAIL unsigned_write[%0d]: addr=%0h dat=%0h cyc=%0d, expected addr=%0h dat=%0h cyc=%0d",
                 i, seq_addr[i], seq_dat[i], seq_cyc[i], i, exp_q[i], 33 + i);
      end
    end
    vectors++;
    if (busy_log[1] !== 1'b1 || busy_log[47] !== 1'b1 || busy_log[48] !== 1'b0 ||
        done_log[46] !== 1'b0 || done_log[47] !== 1'b1 || done_log[48] !== 1'b0) begin
      miscompares++;
      $display("FAIL unsigned_timing: busy1/47/48=%b%b%b done46/47/48=%b%b%b, expected 110 010",
               busy_log[1], busy_log[47], busy_log[48], done_log[46], done_log[47], done_log[48]);
    end
  endtask

  task automatic test_negative();
    run_cmd(32'hFFFF_FF85, 1'b1, 4'd2, 0, 0, 0, 0, 0, 48);
    exp_q = '{8'h03, 8'h02, 8'h01, 8'h0A, 8'h0A, 8'h0A, 8'h0A, 8'h0A,
              8'h0A, 8'h0A, 8'h0A, 8'h0A, 8'h02, 8'h01};
    vectors++;
    if (seq_dat.size() != 14) begin
      miscompares++;
      $display("FAIL negative_count: %0d writes, expected 14", seq_dat.size());
    end
    for (int i = 0; i < 14 && i < seq_dat.size(); i++) begin
      vectors++;
      if (seq_addr[i] !== 32'(i) || seq_dat[i] !== {24'b0, exp_q[i]}) begin
        miscompares++;
        $display("FAIL negative_write[%0d]: addr=%0h dat=%0h, expected addr=%0h dat=%0h",
                 i, seq_addr[i], seq_dat[i], i, exp_q[i]);
      end
    end
  endtask

  task automatic test_min_int();
    run_cmd(32'h8000_0000, 1'b1, 4'd0, 0, 0, 0, 0, 0, 48);
    exp_q = '{8'h08, 8'h04, 8'h06, 8'h03, 8'h08, 8'h04, 8'h07, 8'h04,
              8'h01, 8'h02, 8'h0A, 8'h0A, 8'h00, 8'h01};
    vectors++;
    if (seq_dat.size() != 14) begin
      miscompares++;
      $display("FAIL min_int_count: %0d writes, expected 14", seq_dat.size());
    end
    for (int i = 0; i < 14 && i < seq_dat.size(); i++) begin
      vectors++;
      if (seq_addr[i] !== 32'(i) || seq_dat[i] !== {24'b0, exp_q[i]}) begin
        miscompares++;
        $display("FAIL min_int_write[%0d]: addr=%0h dat=%0h, expected addr=%0h dat=%0h",
                 i, seq_addr[i], seq_dat[i], i, exp_q[i]);
      end
    end
  endtask

  task automatic test_zero_point();
    run_cmd(32'd0, 1'b0, 4'd3, 0, 0, 0, 0, 0, 48);
    exp_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h0A, 8'h0A, 8'h0A,
              8'h0A, 8'h0A, 8'h0A, 8'h0A, 8'h03, 8'h00};
    vectors++;
    if (seq_dat.size() != 14) begin
      miscompares++;
      $display("FAIL zero_point_count: %0d writes, expected 14", seq_dat.size());
    end
    for (int i = 0; i < 14 && i < seq_dat.size(); i++) begin
      vectors++;
      if (seq_addr[i] !== 32'(i) || seq_dat[i] !== {24'b0, exp_q[i]}) begin
        miscompares++;
        $display("FAIL zero_point_write[%0d]: addr=%0h dat=%0h, expected addr=%0h dat=%0h",
                 i, seq_addr[i], seq_dat[i], i, exp_q[i]);
      end
    end
  endtask

  // Largest unsigned value with point=15, which clamps to 11 and so unblanks digits 10..11.
  task automatic test_clamp_max();
    run_cmd(32'hFFFF_FFFF, 1'b0, 4'd15, 0, 0, 0, 0, 0, 48);
    exp_q = '{8'h05, 8'h09, 8'h02, 8'h07, 8'h06, 8'h09, 8'h04, 8'h09,
              8'h02, 8'h04, 8'h00, 8'h00, 8'h0B, 8'h00};
    vectors++;
    if (seq_dat.size() != 14) begin
      miscompares++;
      $display("FAIL clamp_max_count: %0d writes, expected 14", seq_dat.size());
    end
    for (int i = 0; i < 14 && i < seq_dat.size(); i++) begin
      vectors++;
      if (seq_addr[i] !== 32'(i) || seq_dat[i] !== {24'b0, exp_q[i]}) begin
        miscompares++;
        $display("FAIL clamp_max_write[%0d]: addr=%0h dat=%0h, expected addr=%0h dat=%0h",
                 i, seq_addr[i], seq_dat[i], i, exp_q[i]);
      end
    end
  endtask

  task automatic test_cpu_stall();
    run_cmd(32'd1234, 1'b0, 4'd0, 39, 5, 0, 0, 0, 53);
    exp_q = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h0A, 8'h0A, 8'h0A, 8'h0A,
              8'h0A, 8'h0A, 8'h0A, 8'h0A, 8'h00, 8'h00};
    vectors++;
    if (seq_dat.size() != 14) begin
      miscompares++;
      $display("FAIL stall_count: %0d writes, expected 14", seq_dat.size());
    end
    for (int i = 0; i < 14 && i < seq_dat.size(); i++) begin
      vectors++;
      if (seq_addr[i] !== 32'(i) || seq_dat[i] !== {24'b0, exp_q[i]} ||
          seq_cyc[i] != ((i < 6) ? 33 + i : 38 + i)) begin
        miscompares++;
        $display("FAIL stall_write[%0d]: addr=%0h dat=%0h cyc=%0d, expected addr=%0h dat=%0h cyc=%0d",
                 i, seq_addr[i], seq_dat[i], seq_cyc[i], i, exp_q[i], (i < 6) ? 33 + i : 38 + i);
      end
    end
    vectors++;
    if (pass_err != 0) begin
      miscompares++;
      $display("FAIL stall_passthru: %0d cycles differed from CPU signals, expected 0", pass_err);
    end
    vectors++;
    if (done_log[47] !== 1'b0 || done_log[51] !== 1'b0 || done_log[52] !== 1'b1 || busy_log[53] !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_done: done47/51/52=%b%b%b busy53=%b, expected 001 0",
               done_log[47], done_log[51], done_log[52], busy_log[53]);
    end
    vectors++;
    if (mem[7] !== 8'h0A) begin
      miscompares++;
      $display("FAIL stall_last_writer: reg7=%0h, expected 0a", mem[7]);
    end
  endtask

  task automatic test_back_to_back();
    int dones;
    int waited;
    run_cmd(32'd1234, 1'b0, 4'd0, 0, 0, 10, 47, 0, 55);
    vectors++;
    if (seq_dat.size() != 14 || seq_dat[3] !== 32'h1 || seq_dat[4] !== 32'h0A) begin
      miscompares++;
      $display("FAIL b2b_ignored: %0d writes, expected 14 with 1234 digits", seq_dat.size());
    end
    dones = 0;
    for (int n = 1; n <= 55; n++) if (done_log[n] === 1'b1) dones++;
    vectors++;
    if (dones != 1 || busy_log[48] !== 1'b0 || busy_log[55] !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_idle: done pulses=%0d busy48=%b busy55=%b, expected 1 0 0",
               dones, busy_log[48], busy_log[55]);
    end
    run_cmd(32'd5, 1'b0, 4'd0, 0, 0, 48, 0, 0, 50);
    vectors++;
    if (busy_log[48] !== 1'b0 || busy_log[49] !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_accept: busy48=%b busy49=%b, expected 0 1", busy_log[48], busy_log[49]);
    end
    waited = 0;
    while (busy === 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_drain: busy=%b after %0d cycles, expected 0", busy, waited);
    end
  endtask

  task automatic test_mid_reset();
    run_cmd(32'd1234, 1'b0, 4'd0, 0, 0, 0, 0, 36, 40);
    vectors++;
    if (seq_dat.size() != 4) begin
      miscompares++;
      $display("FAIL mid_reset_count: %0d writes, expected 4", seq_dat.size());
    end
    vectors++;
    if (busy_log[37] !== 1'b0 || done_log[37] !== 1'b0 || busy_log[40] !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_status: busy37=%b done37=%b busy40=%b, expected 0 0 0",
               busy_log[37], done_log[37], busy_log[40]);
    end
    vectors++;
    if (mem[3] !== 8'h01) begin
      miscompares++;
      $display("FAIL mid_reset_kept: reg3=%0h, expected 01", mem[3]);
    end
    for (int i = 4; i < 14; i++) begin
      vectors++;
      if (mem[i] !== 8'hEE) begin
        miscompares++;
        $display("FAIL mid_reset_unwritten[%0d]: reg=%0h, expected ee (untouched)", i, mem[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_negative();
    test_min_int();
    test_zero_point();
    test_clamp_max();
    test_cpu_stall();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gpio_display_sequencer.md
# gpio_display_sequencer

Display-update controller that sits between the CPU bus and the GPIO register port that drives the 12 VGA digits, the decimal point and the sign. On a start pulse it converts a 32-bit binary value to BCD and writes all 14 display registers, one per cycle. It shares the GPIO port with the CPU, which always has priority, so software can update the whole display with one command instead of 14 stores.

## Interface
- BASE_ADDR, 32'h0000_0000, GPIO address of display register 0; register i sits at BASE_ADDR + i.
- LZ_BLANK, 1, 1 enables leading-zero blanking.
- BLANK_CODE, 8'h0A, code written to blanked digits.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  reset, synchronous, active-low.
- cpu_req  in  1  CPU is accessing the GPIO port this cycle (read or write).
- cpu_wr_en  in  1  CPU write enable.
- cpu_addr  in  32  CPU address.
- cpu_dat_i  in  32  CPU write data.
- start  in  1  one-cycle command strobe.
- value  in  32  number to display.
- signed_mode  in  1  1 treats value as two's complement.
- point  in  4  number of fractional digits, 0..11; values above 11 clamp to 11.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- gpio_wr_en  out  1  write enable to the GPIO port.
- gpio_addr  out  32  address to the GPIO port.
- gpio_dat  out  32  write data to the GPIO port.

## Operation
- Port mux (combinational):
  - If cpu_req=1 or state is not WRITE: gpio_wr_en=cpu_wr_en, gpio_addr=cpu_addr, gpio_dat=cpu_dat_i.
  - Otherwise: gpio_wr_en=1, gpio_addr=BASE_ADDR+idx, gpio_dat={24'b0, code(idx)}.
- States: IDLE, CONV, WRITE, DONE.
- IDLE: start=1 latches the inputs and moves to CONV.
  - mag = (signed_mode & value[31]) ? -value : value, as a 32-bit unsigned result. 0x8000_0000 gives 2147483648.
  - neg = signed_mode & value[31].
  - pt = min(point, 11).
  - Clear the 40-bit BCD register, set cnt=0.
- CONV: one double-dabble step per cycle for exactly 32 cycles.
  - Add 3 to every BCD nibble that is ≥5.
  - Shift {bcd, mag} left by 1.
  - After step 32, go to WRITE with idx=0.
- WRITE: a write is granted in any cycle with cpu_req=0.
  - On a grant, idx increments; after the grant at idx=13, go to DONE.
  - With cpu_req=1, idx holds and nothing from the sequencer reaches the port.
- DONE: one cycle, then IDLE.
- code(idx):
  - idx 0..9: BCD digit idx (digit 0 is least significant).
  - idx 10..11: 0.
  - idx 12: pt.
  - idx 13: 8'h01 if neg, else 8'h00.
  - Digit idx (0..11) is replaced by BLANK_CODE when LZ_BLANK=1, idx > msd and idx > pt. msd is the index of the highest nonzero BCD digit, or 0 if all digits are zero. Digit 0 is therefore never blanked.
  - A negative zero cannot occur (neg implies mag ≠ 0).
- start is ignored when busy=1; no queueing.
- Outputs: busy = (state != IDLE); done = (state == DONE).
- CPU writes that land on display registers during WRITE are not protected. Any register the sequencer writes later overwrites them (last writer wins).

## Timing
- Reset (rst_n=0 at a clk edge): state=IDLE, idx=0, cnt=0, bcd=0, neg=0, pt=0, busy=0, done=0.
  - gpio_* pass the CPU signals from the next cycle on.
  - Applies mid-command too: no further sequencer writes; registers already written keep their values.
- Start sampled at edge E0:
  - busy=1 from E0 through the DONE cycle.
  - CONV occupies 32 cycles.
- With no contention, the writes for idx 0..13 appear in cycles 33..46 after E0, done=1 in cycle 47, and busy=0 from cycle 48.
- Each cycle with cpu_req=1 during WRITE adds exactly one cycle of latency. CONV is never stalled.
- start in the same cycle as done is ignored; start in the first cycle after DONE is accepted.

## Test plan
- value=1234, signed_mode=0, point=0, LZ_BLANK=1, no CPU traffic -> writes in order: addr 0..3 = 4,3,2,1; addr 4..11 = 0x0A; addr 12 = 0; addr 13 = 0. done in cycle 47 after start.
- value=0xFFFF_FF85 (−123), signed_mode=1, point=2 -> digits 3,2,1; addr 3..11 = 0x0A; addr 12 = 2; addr 13 = 1.
- value=0x8000_0000, signed_mode=1 -> digits 8,4,6,3,8,4,7,4,1,2 at addr 0..9; addr 10..11 = 0x0A; addr 13 = 1. value=0, point=3 -> addr 0..3 = 0, addr 4..11 = 0x0A.
- cpu_req=1 for 5 cycles starting at the write of idx=6, with a CPU write to addr 7 = 0x55 inside the window -> CPU signals pass through unchanged; sequencer resumes at idx=6; addr 7 ends at the sequencer digit; done is 5 cycles late (cycle 52).
- A second start while busy, and a start in the DONE cycle -> both ignored, 14 writes total. rst_n=0 at the write of idx=4 -> idx 4..13 never written, busy=0 and done=0 after the edge.
